countdown_timer: RTL and testbench

Loadable N-bit down counter with a start/stop/pause state machine, terminal-count pulse and borrow-out for cascading. It is the decrementing counterpart to the team's up counters (`binary_counter` family), which produce `cout` on terminal count. It sits alongside them as a programmable delay/interval timer. Several instances chain into a wider timer by feeding one stage's `bout` into the next stage's `enable`.

---
 rtl/countdown_timer_if.sv | 34 +++
 rtl/countdown_timer.sv | 105 ++++++++++
 tb/tb_countdown_timer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// ============================================================================
// Module   : countdown_timer_if
// Brief    : Control/status bundle for countdown_timer (master = controller,
//            slave = timer).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface countdown_timer_if #(
    parameter int N = 4
);
    logic         load;
    logic [N-1:0] din;
    logic         start;
    logic         stop;
    logic         enable;
    logic         auto;
    logic [N-1:0] qout;
    logic         bout;
    logic         done;
    logic         busy;

    modport master (
        output load, din, start, stop, enable, auto,
        input  qout, bout, done, busy
    );

    modport slave (
        input  load, din, start, stop, enable, auto,
        output qout, bout, done, busy
    );
endinterface

`default_nettype wire

// File: rtl/countdown_timer.sv
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable N-bit down counter with IDLE/RUN/PAUSE control,
//            terminal-count pulse and cascadable borrow-out.
//            COUNTDOWN_TIMER_AUTO_RELOAD_EN enables the periodic (auto) mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer #(
    parameter int N = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    countdown_timer_if.slave  bus
);

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_PAUSE = 2'd2;

    state_t       r_state;
    logic [N-1:0] r_qout;
    logic [N-1:0] r_reload;
    logic         r_done;
    logic         r_busy;
    logic [N-1:0] w_start_val;
    logic         w_auto;

    // A start in the same cycle as a load counts from the new value.
    assign w_start_val = bus.load ? bus.din : r_reload;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    assign w_auto = bus.auto;
`else
    logic w_unused_auto;
    assign w_unused_auto = bus.auto;
    assign w_auto        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_qout   <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.load) begin
                r_reload <= bus.din;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_start_val != '0) begin
                            r_qout  <= w_start_val;
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        r_state <= S_PAUSE;
                    end else if (bus.enable) begin
                        if (r_qout != '0) begin
                            r_qout <= r_qout - 1'b1;
                        end else begin
                            r_done <= 1'b1;
                            if (w_auto) begin
                                r_qout <= r_reload;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (bus.start && !bus.stop) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_qout  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Borrow is combinational so a downstream stage can tick in this cycle.
    assign bus.bout = (r_state == S_RUN) && bus.enable && (r_qout == '0);
    assign bus.qout = r_qout;
    assign bus.done = r_done;
    assign bus.busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// Module   : tb_countdown_timer
// Brief    : Self-checking bench for countdown_timer against a behavioural
//            model of the counting rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    localparam bit c_auto_en = 1'b1;
`else
    localparam bit c_auto_en = 1'b0;
`endif

    logic clk;
    logic reset;

    countdown_timer_if #(.N(4)) bus ();

    countdown_timer #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: running/paused flags, count and reload value.
    int m_q   = 0;
    int m_rel = 0;
    bit m_run = 1'b0;
    bit m_pau = 1'b0;
    bit m_done = 1'b0;

    logic [3:0] exp_q, obs_q;
    logic       exp_done, obs_done, exp_busy, obs_busy, exp_bout, obs_bout;

    task automatic step(input logic ld, input logic [3:0] d, input logic st,
                        input logic sp, input logic en, input logic au,
                        input logic rs);
        int sv;
        int new_rel;
        bus.load   = ld;
        bus.din    = d;
        bus.start  = st;
        bus.stop   = sp;
        bus.enable = en;
        bus.auto   = au;
        reset      = rs;
        #1;
        obs_bout = bus.bout;
        exp_bout = m_run && en && (m_q == 0);
        @(posedge clk);
        m_done = 1'b0;
        if (rs) begin
            m_q = 0; m_rel = 0; m_run = 1'b0; m_pau = 1'b0;
        end else begin
            new_rel = ld ? int'(d) : m_rel;
            if (!m_run && !m_pau) begin
                if (st) begin
                    sv = ld ? int'(d) : m_rel;
                    if (sv != 0) begin
                        m_q = sv; m_run = 1'b1;
                    end else begin
                        m_done = 1'b1;
                    end
                end
            end else if (m_run) begin
                if (sp) begin
                    m_run = 1'b0; m_pau = 1'b1;
                end else if (en) begin
                    if (m_q > 0) begin
                        m_q = m_q - 1;
                    end else begin
                        m_done = 1'b1;
                        if (c_auto_en && au) m_q = m_rel;
                        else m_run = 1'b0;
                    end
                end
            end else if (st && !sp) begin
                m_pau = 1'b0; m_run = 1'b1;
            end
            m_rel = new_rel;
        end
        exp_q    = m_q[3:0];
        exp_done = m_done;
        exp_busy = m_run || m_pau;
        #1;
        obs_q    = bus.qout;
        obs_done = bus.done;
        obs_busy = bus.busy;
    endtask

    task automatic test_reset();
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({obs_q, obs_done, obs_busy, bus.bout} !== 7'b0) begin
            n_err++;
            $display("FAIL reset: q/done/busy/bout got %0d/%b/%b/%b want 0/0/0/0",
                     obs_q, obs_done, obs_busy, bus.bout);
        end
    endtask

    task automatic test_oneshot();
        int pulses = 0;
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'd0, (i == 0), 1'b0, 1'b1, 1'b0, 1'b0);
            pulses += int'(obs_done);
            n_cmp++;
            if ({obs_q, obs_done, obs_busy, obs_bout} !== {exp_q, exp_done, exp_busy, exp_bout}) begin
                n_err++;
                $display("FAIL oneshot c%0d: q/done/busy/bout got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_q, obs_done, obs_busy, obs_bout, exp_q, exp_done, exp_busy, exp_bout);
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL oneshot_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_auto();
        int pulses = 0;
        int want = c_auto_en ? 4 : 1;
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 4'd0, (i == 0), 1'b0, 1'b1, 1'b1, 1'b0);
            pulses += int'(obs_done);
            n_cmp++;
            if ({obs_q, obs_done, obs_busy, obs_bout} !== {exp_q, exp_done, exp_busy, exp_bout}) begin
                n_err++;
                $display("FAIL auto c%0d: q/done/busy/bout got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_q, obs_done, obs_busy, obs_bout, exp_q, exp_done, exp_busy, exp_bout);
            end
        end
        n_cmp++;
        if (pulses != want) begin
            n_err++;
            $display("FAIL auto_pulses: got %0d want %0d", pulses, want);
        end
        // Leave the timer idle for the next scenario.
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_pause();
        logic st, sp;
        step(1'b1, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_q != 5; i++) begin
            step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        // 4 stopped cycles, resume, then stop and try start+stop together.
        for (int i = 0; i < 10; i++) begin
            st = (i == 4) || (i == 7) || (i == 8);
            sp = (i < 4) || (i == 6) || (i == 7);
            step(1'b0, 4'd0, st, sp, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if ({obs_q, obs_done, obs_busy, obs_bout} !== {exp_q, exp_done, exp_busy, exp_bout}) begin
                n_err++;
                $display("FAIL pause c%0d: q/done/busy/bout got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_q, obs_done, obs_busy, obs_bout, exp_q, exp_done, exp_busy, exp_bout);
            end
        end
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_enable_toggle();
        step(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 4'd0, 1'b0, 1'b0, i[0], 1'b0, 1'b0);
            n_cmp++;
            if ({obs_q, obs_done, obs_busy, obs_bout} !== {exp_q, exp_done, exp_busy, exp_bout}) begin
                n_err++;
                $display("FAIL enable c%0d: q/done/busy/bout got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_q, obs_done, obs_busy, obs_bout, exp_q, exp_done, exp_busy, exp_bout);
            end
        end
    endtask

    task automatic test_zero_reload();
        step(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0, (i == 0), 1'b0, 1'b1, 1'b0, 1'b0);
            n_cmp++;
            if ({obs_q, obs_done, obs_busy} !== {4'd0, (i == 0), 1'b0}) begin
                n_err++;
                $display("FAIL zero_reload c%0d: q/done/busy got %0d/%b/%b want 0/%b/0",
                         i, obs_q, obs_done, obs_busy, (i == 0));
            end
        end
    endtask

    task automatic test_reset_midway();
        step(1'b1, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_q != 7; i++) begin
            step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        // Start without load exposes the cleared reload register (done, no run).
        for (int i = 0; i < 14; i++) begin
            step((i == 8), 4'd6, (i == 2) || (i == 8), 1'b0, (i > 8), 1'b0, 1'b0);
            n_cmp++;
            if ({obs_q, obs_done, obs_busy, obs_bout} !== {exp_q, exp_done, exp_busy, exp_bout}) begin
                n_err++;
                $display("FAIL reset_mid c%0d: q/done/busy/bout got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_q, obs_done, obs_busy, obs_bout, exp_q, exp_done, exp_busy, exp_bout);
            end
        end
        n_cmp++;
        if (obs_q !== 4'd1 || obs_busy !== 1'b1) begin
            n_err++;
            $display("FAIL load_start: q/busy got %0d/%b want 1/1", obs_q, obs_busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 8) == 0, 4'($urandom), ($urandom % 4) == 0,
                 ($urandom % 8) == 0, ($urandom % 4) != 0, 1'($urandom),
                 ($urandom % 64) == 0);
            n_cmp++;
            if ({obs_q, obs_done, obs_busy, obs_bout} !== {exp_q, exp_done, exp_busy, exp_bout}) begin
                n_err++;
                $display("FAIL random c%0d: q/done/busy/bout got %0d/%b/%b/%b want %0d/%b/%b/%b",
                         i, obs_q, obs_done, obs_busy, obs_bout, exp_q, exp_done, exp_busy, exp_bout);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.load   = 1'b0;
        bus.din    = 4'd0;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.enable = 1'b0;
        bus.auto   = 1'b0;
        test_reset();
        test_oneshot();
        test_auto();
        test_pause();
        test_enable_toggle();
        test_zero_reload();
        test_reset_midway();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
